// File: rtl/uart_cmd_responder_if.sv
// Byte-level handshake between a UART parallel port and the command responder.
// master = UART side (drives received bytes, reports tx busy); slave = responder.
interface uart_cmd_responder_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_p_data;
    logic                  rx_d_valid;
    logic                  tx_busy;
    logic [DATA_WIDTH-1:0] tx_p_data;
    logic                  tx_d_valid;

    modport master (
        output rx_p_data, rx_d_valid, tx_busy,
        input  tx_p_data, tx_d_valid
    );

    modport slave (
        input  rx_p_data, rx_d_valid, tx_busy,
        output tx_p_data, tx_d_valid
    );
endinterface

// File: rtl/uart_cmd_responder.sv
// Decodes write/read command frames arriving as UART bytes against a small register
// file and returns read data (or an error byte) through the UART transmitter.
module uart_cmd_responder #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
    parameter logic [DATA_WIDTH-1:0] ERR_CODE   = 8'hEE
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_cmd_responder_if.slave   bus,
    output logic [DATA_WIDTH-1:0] cfg_reg0,
    output logic [DATA_WIDTH-1:0] cfg_reg1,
    output logic                  overrun
);
    localparam int NREGS = 1 << ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] REG0_RST = 8'h81;
    localparam logic [DATA_WIDTH-1:0] REG1_RST = 8'h20;

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RSP_REQ, RSP_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic                  ovr_q, ovr_d;
    logic                  we;
    logic [DATA_WIDTH-1:0] regs_q [NREGS];

    logic                  rx_v;
    logic [DATA_WIDTH-1:0] rx_b;
    logic                  in_rsp;

    assign rx_v   = bus.rx_d_valid;
    assign rx_b   = bus.rx_p_data;
    assign in_rsp = (state_q == RSP_REQ) || (state_q == RSP_WAIT);

    // Upper address bits must be clear, otherwise the access is rejected.
    function automatic logic addr_ok(input logic [DATA_WIDTH-1:0] a);
        return a[DATA_WIDTH-1:ADDR_WIDTH] == '0;
    endfunction

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tx_d    = tx_q;
        we      = 1'b0;
        ovr_d   = rx_v && in_rsp;
        unique case (state_q)
            IDLE: begin
                if (rx_v) begin
                    if (rx_b == WR_CMD) begin
                        state_d = WR_ADDR;
                    end else if (rx_b == RD_CMD) begin
                        state_d = RD_ADDR;
                    end else begin
                        tx_d    = ERR_CODE;
                        state_d = RSP_REQ;
                    end
                end
            end
            WR_ADDR: begin
                if (rx_v) begin
                    addr_d  = rx_b;
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (rx_v) begin
                    if (addr_ok(addr_q)) begin
                        we      = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tx_d    = ERR_CODE;
                        state_d = RSP_REQ;
                    end
                end
            end
            RD_ADDR: begin
                if (rx_v) begin
                    tx_d    = addr_ok(rx_b) ? regs_q[rx_b[ADDR_WIDTH-1:0]] : ERR_CODE;
                    state_d = RSP_REQ;
                end
            end
            RSP_REQ: begin
                if (bus.tx_busy) state_d = RSP_WAIT;
            end
            RSP_WAIT: begin
                if (!bus.tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            tx_q    <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tx_q    <= tx_d;
            ovr_q   <= ovr_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NREGS; i++) begin
                if (i == 0)      regs_q[i] <= REG0_RST;
                else if (i == 1) regs_q[i] <= REG1_RST;
                else             regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[addr_q[ADDR_WIDTH-1:0]] <= rx_b;
        end
    end

    // Request is a pure function of state so it drops the instant reset asserts.
    assign bus.tx_d_valid = (state_q == RSP_REQ);
    assign bus.tx_p_data  = tx_q;
    assign cfg_reg0       = regs_q[0];
    assign cfg_reg1       = regs_q[1];
    assign overrun        = ovr_q;
endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: frames, errors, overrun and reset recovery.
module tb_uart_cmd_responder;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] cfg_reg0, cfg_reg1;
    logic       overrun;
    int         n_chk  = 0;
    int         n_pass = 0;

    uart_cmd_responder_if #(.DATA_WIDTH(8)) bus ();

    uart_cmd_responder dut (
        .CLK      (CLK),
        .RST      (RST),
        .bus      (bus),
        .cfg_reg0 (cfg_reg0),
        .cfg_reg1 (cfg_reg1),
        .overrun  (overrun)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Strobe one byte; returns #1 after the edge that consumed it.
    task automatic send(input logic [7:0] b);
        @(posedge CLK); #1;
        bus.rx_p_data  = b;
        bus.rx_d_valid = 1'b1;
        @(posedge CLK); #1;
        bus.rx_d_valid = 1'b0;
    endtask

    // Expect a response now, hold it without busy, then complete the busy handshake.
    task automatic rsp(input string tag, input logic [7:0] exp);
        chk({tag, "_vld"}, bus.tx_d_valid, 1);
        chk({tag, "_dat"}, bus.tx_p_data, exp);
        repeat (2) @(posedge CLK);
        #1 chk({tag, "_hold"}, bus.tx_d_valid, 1);
        bus.tx_busy = 1'b1;
        @(posedge CLK); #1;
        chk({tag, "_wait"}, bus.tx_d_valid, 0);
        repeat (2) @(posedge CLK);
        #1 bus.tx_busy = 1'b0;
        @(posedge CLK); #1;
        chk({tag, "_idle"}, bus.tx_d_valid, 0);
    endtask

    initial begin
        bus.rx_p_data  = '0;
        bus.rx_d_valid = 1'b0;
        bus.tx_busy    = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_cfg0", cfg_reg0, 8'h81);
        chk("rst_cfg1", cfg_reg1, 8'h20);
        chk("rst_vld", bus.tx_d_valid, 0);
        chk("rst_txd", bus.tx_p_data, 0);
        chk("rst_ovr", overrun, 0);
        RST = 1'b1;

        // write then read back reg 3
        send(8'hAA); send(8'h03); send(8'h5C);
        chk("wr3_novld", bus.tx_d_valid, 0);
        repeat (2) @(posedge CLK);
        #1 chk("wr3_novld2", bus.tx_d_valid, 0);
        send(8'hBB); send(8'h03);
        rsp("rd3", 8'h5C);

        // write reg 0 is visible on cfg_reg0 the cycle after the data strobe
        send(8'hAA); send(8'h00);
        chk("cfg0_before", cfg_reg0, 8'h81);
        send(8'h3F);
        chk("cfg0_after", cfg_reg0, 8'h3F);
        chk("cfg0_novld", bus.tx_d_valid, 0);

        // error paths
        send(8'h7E);
        rsp("badcmd", 8'hEE);
        send(8'hBB); send(8'h10);
        rsp("rd_oor", 8'hEE);
        send(8'hAA); send(8'h21); send(8'h55);
        rsp("wr_oor", 8'hEE);
        chk("oor_cfg0", cfg_reg0, 8'h3F);
        chk("oor_cfg1", cfg_reg1, 8'h20);
        send(8'hBB); send(8'h01);
        rsp("rd1_a", 8'h20);

        // busy seen in IDLE is ignored
        bus.tx_busy = 1'b1;
        repeat (2) @(posedge CLK);
        #1 bus.tx_busy = 1'b0;
        chk("idle_busy", bus.tx_d_valid, 0);

        // overrun: byte arriving while in RSP_WAIT is dropped
        send(8'h7E);
        chk("ovr_vld", bus.tx_d_valid, 1);
        bus.tx_busy = 1'b1;
        @(posedge CLK); #1;
        chk("ovr_quiet", overrun, 0);
        send(8'hAA);
        chk("ovr_pulse", overrun, 1);
        chk("ovr_stay", bus.tx_d_valid, 0);
        @(posedge CLK); #1;
        chk("ovr_clear", overrun, 0);
        bus.tx_busy = 1'b0;
        @(posedge CLK); #1;
        send(8'hBB); send(8'h01);
        rsp("rd1_b", 8'h20);

        // reset mid-frame discards the partial write and restores registers
        send(8'hAA); send(8'h05);
        RST = 1'b0;
        #2;
        chk("rst2_cfg0", cfg_reg0, 8'h81);
        chk("rst2_vld", bus.tx_d_valid, 0);
        @(posedge CLK); #1;
        RST = 1'b1;
        send(8'hBB); send(8'h05);
        rsp("rd5", 8'h00);
        send(8'hBB); send(8'h03);
        rsp("rd3_rst", 8'h00);

        // reset mid-response drops the request at once
        send(8'hBB); send(8'h00);
        chk("rst3_pre", bus.tx_d_valid, 1);
        RST = 1'b0;
        #1 chk("rst3_vld", bus.tx_d_valid, 0);
        @(posedge CLK); #1;
        RST = 1'b1;
        send(8'hBB); send(8'h00);
        rsp("rd0", 8'h81);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
